// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and three-stage sequencer (accept / access /
// response) in front of a single-port word data memory. m0 can hold the
// memory across several transactions with m0_lock. Every accepted address is
// checked for alignment, range and the MMIO hole.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MMIO_BIT = 8,
  parameter int TOP_BIT  = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_lock,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  // An access is illegal when misaligned or when any bit at or above TOP_BIT is set.
  function automatic logic addr_err(input logic [AW-1:0] addr);
    addr_err = (|addr[1:0]) | (|addr[AW-1:TOP_BIT]);
  endfunction

  // Round-robin pointer: 1 means m1 was granted last, so m0 wins the next tie.
  logic          r_last_m1;

  // Stage S (memory access)
  logic          r_s_v;
  logic          r_s_we;
  logic [AW-1:0] r_s_addr;
  logic [DW-1:0] r_s_wdata;
  logic          r_s_id;
  logic          r_s_err;

  // Stage R (response)
  logic          r_r_v;
  logic          r_r_id;
  logic          r_r_err;
  logic [DW-1:0] r_r_rdata;

  // Stage A combinational results
  logic          w_lock_hold;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_acc_v;
  logic          w_acc_id;
  logic          w_acc_we;
  logic [AW-1:0] w_acc_addr;
  logic [DW-1:0] w_acc_wdata;
  logic          w_acc_err;
  logic          w_rd_ok;

  // The lock only binds while m0 owns the last grant; it ends as soon as m0_lock falls.
  assign w_lock_hold = ~r_last_m1 & m0_lock;

  // Arbitration: lock first, then round-robin on a tie, else the single requester.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (w_lock_hold) begin
      w_gnt0 = m0_req;
      w_gnt1 = 1'b0;
    end else if (m0_req && m1_req) begin
      w_gnt0 = r_last_m1;
      w_gnt1 = ~r_last_m1;
    end else begin
      w_gnt0 = m0_req;
      w_gnt1 = m1_req;
    end
  end

  // Select the granted master's transaction fields; zero them when nobody is accepted.
  always_comb begin
    w_acc_v     = w_gnt0 | w_gnt1;
    w_acc_id    = 1'b0;
    w_acc_we    = 1'b0;
    w_acc_addr  = {AW{1'b0}};
    w_acc_wdata = {DW{1'b0}};
    if (w_gnt1) begin
      w_acc_id    = 1'b1;
      w_acc_we    = m1_we;
      w_acc_addr  = m1_addr;
      w_acc_wdata = m1_wdata;
    end else if (w_gnt0) begin
      w_acc_id    = 1'b0;
      w_acc_we    = m0_we;
      w_acc_addr  = m0_addr;
      w_acc_wdata = m0_wdata;
    end else begin
      w_acc_id    = 1'b0;
      w_acc_we    = 1'b0;
      w_acc_addr  = {AW{1'b0}};
      w_acc_wdata = {DW{1'b0}};
    end
    w_acc_err = w_acc_v & addr_err(w_acc_addr);
  end

  // Track the last grantee; idle cycles leave the pointer unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_m1 <= 1'b1;
    end else if (w_gnt0) begin
      r_last_m1 <= 1'b0;
    end else if (w_gnt1) begin
      r_last_m1 <= 1'b1;
    end else begin
      r_last_m1 <= r_last_m1;
    end
  end

  // Stage S register: captures the accepted transaction for the memory access cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_v     <= 1'b0;
      r_s_we    <= 1'b0;
      r_s_addr  <= {AW{1'b0}};
      r_s_wdata <= {DW{1'b0}};
      r_s_id    <= 1'b0;
      r_s_err   <= 1'b0;
    end else begin
      r_s_v     <= w_acc_v;
      r_s_we    <= w_acc_we;
      r_s_addr  <= w_acc_addr;
      r_s_wdata <= w_acc_wdata;
      r_s_id    <= w_acc_id;
      r_s_err   <= w_acc_err;
    end
  end

  // Memory is driven straight from stage S; erroneous and MMIO writes never reach it.
  assign mem_we  = r_s_v & r_s_we & ~r_s_err & ~r_s_addr[MMIO_BIT];
  assign mem_a   = r_s_v ? r_s_addr  : {AW{1'b0}};
  assign mem_wd  = r_s_v ? r_s_wdata : {DW{1'b0}};
  assign w_rd_ok = r_s_v & ~r_s_we & ~r_s_err & ~r_s_addr[MMIO_BIT];

  // Stage R register: read data only for clean memory reads, zero for writes/errors/MMIO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_r_v     <= 1'b0;
      r_r_id    <= 1'b0;
      r_r_err   <= 1'b0;
      r_r_rdata <= {DW{1'b0}};
    end else begin
      r_r_v     <= r_s_v;
      r_r_id    <= r_s_id;
      r_r_err   <= r_s_v & r_s_err;
      r_r_rdata <= w_rd_ok ? mem_rd : {DW{1'b0}};
    end
  end

  // Grants are combinational; responses are steered to the owning master only.
  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign m0_rvalid = r_r_v & ~r_r_id;
  assign m1_rvalid = r_r_v & r_r_id;
  assign m0_rdata  = m0_rvalid ? r_r_rdata : {DW{1'b0}};
  assign m1_rdata  = m1_rvalid ? r_r_rdata : {DW{1'b0}};
  assign m0_err    = m0_rvalid & r_r_err;
  assign m1_err    = m1_rvalid & r_r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus a hand-written
// reset-mid-flight sequence, with a 64-word behavioural memory attached.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_lock;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int n_checks;
  int n_fail;

  logic        mem_init;
  logic [31:0] mem [64];
  logic        saw_we;
  logic        saw_rv1;

  dmem_arbiter #(.AW(32), .DW(32), .MMIO_BIT(8), .TOP_BIT(9)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, synchronous write, preload while mem_init.
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'h0000_0100 + k;
      mem[0] <= 32'h0000_0003;
      mem[1] <= 32'h0000_0009;
      mem[2] <= 32'h0000_000c;
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  // Sticky monitors used by the reset-mid-flight sequence.
  always @(negedge clk) begin
    if (mem_we) saw_we <= 1'b1;
    if (m1_rvalid) saw_rv1 <= 1'b1;
  end

  typedef struct {
    logic m0r, m0w; logic [31:0] m0a, m0d; logic lk;
    logic m1r, m1w; logic [31:0] m1a, m1d;
    logic g0, g1, we; logic [31:0] a, wd;
    logic rv0; logic [31:0] rd0; logic er0;
    logic rv1; logic [31:0] rd1; logic er1;
  } vec_t;

  function automatic vec_t mkv(
    input logic m0r, m0w, input logic [31:0] m0a, m0d, input logic lk,
    input logic m1r, m1w, input logic [31:0] m1a, m1d,
    input logic g0, g1, we, input logic [31:0] a, wd,
    input logic rv0, input logic [31:0] rd0, input logic er0,
    input logic rv1, input logic [31:0] rd1, input logic er1);
    vec_t t;
    t.m0r = m0r; t.m0w = m0w; t.m0a = m0a; t.m0d = m0d; t.lk = lk;
    t.m1r = m1r; t.m1w = m1w; t.m1a = m1a; t.m1d = m1d;
    t.g0 = g0; t.g1 = g1; t.we = we; t.a = a; t.wd = wd;
    t.rv0 = rv0; t.rd0 = rd0; t.er0 = er0;
    t.rv1 = rv1; t.rd1 = rd1; t.er1 = er1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[26];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    saw_we   = 1'b0;
    saw_rv1  = 1'b0;

    //        m0: r  w  addr          wdata         lk  m1: r  w  addr          wdata          g0 g1 we mem_a         mem_wd        rv0 rd0           e0  rv1 rd1           e1
    vecs[0]  = mkv(1'b1,1'b0,32'h0000_0004,32'h0,1'b0, 1'b0,1'b0,32'h0,32'h0,             1'b1,1'b0,1'b0,32'h0,32'h0,             1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0);
    vecs[1]  = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b0,1'b0,32'h0,32'h0,             1'b0,1'b0,1'b0,32'h0000_0004,32'h0,     1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0);
    vecs[2]  = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b0,1'b0,32'h0,32'h0,             1'b0,1'b0,1'b0,32'h0,32'h0,             1'b1,32'h9,1'b0, 1'b0,32'h0,1'b0);
    // contention: m0 was last, so m1 wins the first tie here
    vecs[3]  = mkv(1'b1,1'b0,32'h0,32'h0,1'b0,          1'b1,1'b0,32'h8,32'h0,             1'b0,1'b1,1'b0,32'h0,32'h0,             1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0);
    vecs[4]  = mkv(1'b1,1'b0,32'h0,32'h0,1'b0,          1'b1,1'b0,32'h8,32'h0,             1'b1,1'b0,1'b0,32'h8,32'h0,             1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0);
    vecs[5]  = mkv(1'b1,1'b0,32'h0,32'h0,1'b0,          1'b1,1'b0,32'h8,32'h0,             1'b0,1'b1,1'b0,32'h0,32'h0,             1'b0,32'h0,1'b0, 1'b1,32'hc,1'b0);
    vecs[6]  = mkv(1'b1,1'b0,32'h0,32'h0,1'b0,          1'b1,1'b0,32'h8,32'h0,             1'b1,1'b0,1'b0,32'h8,32'h0,             1'b1,32'h3,1'b0, 1'b0,32'h0,1'b0);
    vecs[7]  = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b0,1'b0,32'h0,32'h0,             1'b0,1'b0,1'b0,32'h0,32'h0,             1'b0,32'h0,1'b0, 1'b1,32'hc,1'b0);
    // m1 write 0x55 to 0x10, then m0 reads it back
    vecs[8]  = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b1,1'b1,32'h10,32'h55,           1'b0,1'b1,1'b0,32'h0,32'h0,             1'b1,32'h3,1'b0, 1'b0,32'h0,1'b0);
    vecs[9]  = mkv(1'b1,1'b0,32'h10,32'h0,1'b0,         1'b0,1'b0,32'h0,32'h0,             1'b1,1'b0,1'b1,32'h10,32'h55,           1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0);
    vecs[10] = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b0,1'b0,32'h0,32'h0,             1'b0,1'b0,1'b0,32'h10,32'h0,            1'b0,32'h0,1'b0, 1'b1,32'h0,1'b0);
    vecs[11] = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b0,1'b0,32'h0,32'h0,             1'b0,1'b0,1'b0,32'h0,32'h0,             1'b1,32'h55,1'b0,1'b0,32'h0,1'b0);
    // address checks: MMIO write, misaligned, out of range, MMIO read
    vecs[12] = mkv(1'b1,1'b1,32'h104,32'h77,1'b0,       1'b0,1'b0,32'h0,32'h0,             1'b1,1'b0,1'b0,32'h0,32'h0,             1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0);
    vecs[13] = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b1,1'b0,32'h6,32'h0,             1'b0,1'b1,1'b0,32'h104,32'h77,          1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0);
    vecs[14] = mkv(1'b1,1'b0,32'h200,32'h0,1'b0,        1'b0,1'b0,32'h0,32'h0,             1'b1,1'b0,1'b0,32'h6,32'h0,             1'b1,32'h0,1'b0, 1'b0,32'h0,1'b0);
    vecs[15] = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b1,1'b0,32'h104,32'h0,           1'b0,1'b1,1'b0,32'h200,32'h0,           1'b0,32'h0,1'b0, 1'b1,32'h0,1'b1);
    vecs[16] = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b0,1'b0,32'h0,32'h0,             1'b0,1'b0,1'b0,32'h104,32'h0,           1'b1,32'h0,1'b1, 1'b0,32'h0,1'b0);
    vecs[17] = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b0,1'b0,32'h0,32'h0,             1'b0,1'b0,1'b0,32'h0,32'h0,             1'b0,32'h0,1'b0, 1'b1,32'h0,1'b0);
    vecs[18] = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b0,1'b0,32'h0,32'h0,             1'b0,1'b0,1'b0,32'h0,32'h0,             1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0);
    // lock: m0 holds for 3 grants, then one cycle with req=0 but lock=1, then release
    vecs[19] = mkv(1'b1,1'b0,32'h4,32'h0,1'b1,          1'b1,1'b0,32'h8,32'h0,             1'b1,1'b0,1'b0,32'h0,32'h0,             1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0);
    vecs[20] = mkv(1'b1,1'b0,32'h4,32'h0,1'b1,          1'b1,1'b0,32'h8,32'h0,             1'b1,1'b0,1'b0,32'h4,32'h0,             1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0);
    vecs[21] = mkv(1'b1,1'b0,32'h4,32'h0,1'b1,          1'b1,1'b0,32'h8,32'h0,             1'b1,1'b0,1'b0,32'h4,32'h0,             1'b1,32'h9,1'b0, 1'b0,32'h0,1'b0);
    vecs[22] = mkv(1'b0,1'b0,32'h0,32'h0,1'b1,          1'b1,1'b0,32'h8,32'h0,             1'b0,1'b0,1'b0,32'h4,32'h0,             1'b1,32'h9,1'b0, 1'b0,32'h0,1'b0);
    vecs[23] = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b1,1'b0,32'h8,32'h0,             1'b0,1'b1,1'b0,32'h0,32'h0,             1'b1,32'h9,1'b0, 1'b0,32'h0,1'b0);
    vecs[24] = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b0,1'b0,32'h0,32'h0,             1'b0,1'b0,1'b0,32'h8,32'h0,             1'b0,32'h0,1'b0, 1'b0,32'h0,1'b0);
    vecs[25] = mkv(1'b0,1'b0,32'h0,32'h0,1'b0,          1'b0,1'b0,32'h0,32'h0,             1'b0,1'b0,1'b0,32'h0,32'h0,             1'b0,32'h0,1'b0, 1'b1,32'hc,1'b0);

    // Reset state, with both requests asserted to show grants are forced low.
    reset = 1'b1; mem_init = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4; m0_wdata = 32'h0; m0_lock = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8; m1_wdata = 32'h1;
    repeat (3) tick();
    chk("rst_gnt0",   {31'h0, m0_gnt},    32'h0);
    chk("rst_gnt1",   {31'h0, m1_gnt},    32'h0);
    chk("rst_mem_we", {31'h0, mem_we},    32'h0);
    chk("rst_mem_a",  mem_a,              32'h0);
    chk("rst_rv0",    {31'h0, m0_rvalid}, 32'h0);
    chk("rst_rv1",    {31'h0, m1_rvalid}, 32'h0);
    chk("rst_rdata1", m1_rdata,           32'h0);
    reset = 1'b0; mem_init = 1'b0;

    // Table-driven section: inputs for one cycle, outputs checked mid-cycle.
    for (int i = 0; i < 26; i++) begin
      m0_req = vecs[i].m0r; m0_we = vecs[i].m0w; m0_addr = vecs[i].m0a;
      m0_wdata = vecs[i].m0d; m0_lock = vecs[i].lk;
      m1_req = vecs[i].m1r; m1_we = vecs[i].m1w; m1_addr = vecs[i].m1a;
      m1_wdata = vecs[i].m1d;
      #2;
      chk($sformatf("v%0d_gnt0", i),   {31'h0, m0_gnt},    {31'h0, vecs[i].g0});
      chk($sformatf("v%0d_gnt1", i),   {31'h0, m1_gnt},    {31'h0, vecs[i].g1});
      chk($sformatf("v%0d_mem_we", i), {31'h0, mem_we},    {31'h0, vecs[i].we});
      chk($sformatf("v%0d_mem_a", i),  mem_a,              vecs[i].a);
      chk($sformatf("v%0d_mem_wd", i), mem_wd,             vecs[i].wd);
      chk($sformatf("v%0d_rv0", i),    {31'h0, m0_rvalid}, {31'h0, vecs[i].rv0});
      chk($sformatf("v%0d_rdata0", i), m0_rdata,           vecs[i].rd0);
      chk($sformatf("v%0d_err0", i),   {31'h0, m0_err},    {31'h0, vecs[i].er0});
      chk($sformatf("v%0d_rv1", i),    {31'h0, m1_rvalid}, {31'h0, vecs[i].rv1});
      chk($sformatf("v%0d_rdata1", i), m1_rdata,           vecs[i].rd1);
      chk($sformatf("v%0d_err1", i),   {31'h0, m1_err},    {31'h0, vecs[i].er1});
      tick();
    end
    chk("mem_0x10_after_write", mem[4], 32'h55);
    chk("mem_mmio_untouched",   mem[1], 32'h9);

    // Reset mid-flight: m1 write granted, reset the following cycle.
    saw_we = 1'b0; saw_rv1 = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_lock = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hAA;
    #2;
    chk("mf_gnt1", {31'h0, m1_gnt}, 32'h1);
    tick();
    reset = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8;
    #2;
    chk("mf_rst_gnt0",   {31'h0, m0_gnt}, 32'h0);
    chk("mf_rst_gnt1",   {31'h0, m1_gnt}, 32'h0);
    chk("mf_rst_mem_we", {31'h0, mem_we}, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    #2;
    chk("mf_first_gnt0", {31'h0, m0_gnt}, 32'h1);
    chk("mf_first_gnt1", {31'h0, m1_gnt}, 32'h0);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    chk("mf_rv0",    {31'h0, m0_rvalid}, 32'h1);
    chk("mf_rdata0", m0_rdata,           32'h3);
    repeat (2) tick();
    chk("mf_no_mem_we",   {31'h0, saw_we},  32'h0);
    chk("mf_no_rv1",      {31'h0, saw_rv1}, 32'h0);
    chk("mf_mem_0x20",    mem[8],           32'h0000_0108);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
